// File: rtl/div_result_fifo.sv
// -----------------------------------------------------------------------------
// div_result_fifo
//
// Purpose:
//   Result buffer between the restoring divider and its consumer. It accepts
//   {quotient, remainder} pairs on the divider's dst_valid/dst_ready handshake
//   and holds up to DEPTH of them. This lets the divider go back to IDLE and
//   take new operands while the consumer is stalled. Results leave in order
//   on a registered valid/ready interface. There is no fall-through: a pushed
//   entry first appears on out_* in the cycle after the push edge.
//
// Ports:
//   clk            in   1              rising-edge clock
//   reset          in   1              asynchronous, active-high reset
//   in_valid       in   1              result offered (divider dst_valid)
//   in_ready       out  1              buffer can accept (divider dst_ready)
//   in_quotient    in   WIDTH          quotient of offered result
//   in_remainder   in   WIDTH          remainder of offered result
//   out_valid      out  1              head entry available
//   out_ready      in   1              consumer takes head entry
//   out_quotient   out  WIDTH          head entry quotient
//   out_remainder  out  WIDTH          head entry remainder
//   count          out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module div_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_quotient,
    input  logic [WIDTH-1:0]           in_remainder,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_quotient,
    output logic [WIDTH-1:0]           out_remainder,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic push;
    logic pop;

    // in_ready comes only from the occupancy register, so a pop while full
    // cannot open the input in the same cycle.
    assign in_ready = (count_q != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge. If that slot is being written on this same edge, the
    // array has not caught up yet, so the incoming data is taken instead.
    // While the buffer stays empty the last head value is held.
    always_comb begin
        out_valid_d = (count_d != '0);
        out_data_d  = out_data_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = {in_quotient, in_remainder};
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage contents are don't-care after reset; occupancy tracks validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_quotient, in_remainder};
        end
    end

    assign out_valid     = out_valid_q;
    assign out_quotient  = out_data_q[DW-1:WIDTH];
    assign out_remainder = out_data_q[WIDTH-1:0];
    assign count         = count_q;

endmodule

// File: tb/tb_div_result_fifo.sv
module tb_div_result_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_quotient = '0;
    logic [W-1:0]  in_remainder = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_quotient;
    logic [W-1:0]  out_remainder;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    div_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_quotient   (in_quotient),
        .in_remainder  (in_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .count         (count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of {q, r}, bounded at D entries.
    logic [2*W-1:0] mq[$];
    logic [W-1:0]   pop_log[$];
    logic           m_push, m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() != D);
            if (m_pop) begin
                pop_log.push_back(mq[0][2*W-1:W]);
                void'(mq.pop_front());
            end
            if (m_push) mq.push_back({in_quotient, in_remainder});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_count", 64'(count), 64'(mq.size()));
            chk("cmp_out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("cmp_in_ready", 64'(in_ready), 64'(mq.size() != D));
            if (mq.size() != 0) begin
                chk("cmp_out_q", 64'(out_quotient), 64'(mq[0][2*W-1:W]));
                chk("cmp_out_r", 64'(out_remainder), 64'(mq[0][W-1:0]));
            end
        end
    end

    task automatic set_in(input logic v, input logic [W-1:0] q, input logic [W-1:0] r, input logic rdy);
        in_valid     = v;
        in_quotient  = q;
        in_remainder = r;
        out_ready    = rdy;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_in(1'b0, '0, '0, 1'b1);
        while (mq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", mq.size());
        end
        set_in(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int idx;
        int n;

        // Reset state
        #1;
        chk("rst_count", 64'(count), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_q", 64'(out_quotient), 0);
        chk("rst_out_r", 64'(out_remainder), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single pass
        @(negedge clk);
        set_in(1'b1, 7, 3, 1'b0);
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 1);
        chk("single_q", 64'(out_quotient), 7);
        chk("single_r", 64'(out_remainder), 3);
        chk("single_count", 64'(count), 1);
        set_in(1'b0, 0, 0, 1'b1);
        @(negedge clk);
        chk("single_pop_valid", 64'(out_valid), 0);
        chk("single_pop_count", 64'(count), 0);
        set_in(1'b0, 0, 0, 1'b0);

        // Fill and hold off a fifth result
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, W'(i), W'(i * 10), 1'b0);
            @(negedge clk);
        end
        chk("fill_count", 64'(count), 4);
        chk("fill_in_ready", 64'(in_ready), 0);
        chk("fill_head", 64'(out_quotient), 1);
        set_in(1'b1, 5, 50, 1'b0);
        @(negedge clk);
        chk("held_count", 64'(count), 4);
        set_in(1'b1, 5, 50, 1'b1);
        @(negedge clk);
        chk("pop_full_count", 64'(count), 3);
        chk("pop_full_in_ready", 64'(in_ready), 1);
        chk("pop_full_head", 64'(out_quotient), 2);
        set_in(1'b1, 5, 50, 1'b0);
        @(negedge clk);
        chk("fifth_count", 64'(count), 4);
        pop_log.delete();
        drain();
        chk("fill_order_n", 64'(pop_log.size()), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            chk("fill_order", 64'(pop_log[i]), 64'(i + 2));

        // Order and wrap with random consumer stalls
        pop_log.delete();
        idx = 0;
        n = 0;
        while ((idx < 10 || mq.size() != 0) && n < 300) begin
            out_ready    = 1'($urandom_range(0, 1));
            in_valid     = (idx < 10);
            in_quotient  = W'(100 + idx);
            in_remainder = W'(idx);
            if (idx < 10 && mq.size() != D) idx++;
            @(negedge clk);
            n++;
        end
        set_in(1'b0, 0, 0, 1'b0);
        if (n >= 300) begin
            errors++;
            $display("FAIL wrap_timeout actual=%0d required=10", idx);
        end
        chk("wrap_n", 64'(pop_log.size()), 10);
        for (int i = 0; i < 10 && i < pop_log.size(); i++)
            chk("wrap_order", 64'(pop_log[i]), 64'(100 + i));

        // Simultaneous push and pop at count=2
        set_in(1'b1, 20, 1, 1'b0);
        @(negedge clk);
        set_in(1'b1, 21, 2, 1'b0);
        @(negedge clk);
        chk("pp_pre_count", 64'(count), 2);
        set_in(1'b1, 22, 3, 1'b1);
        @(negedge clk);
        chk("pp_count", 64'(count), 2);
        chk("pp_head", 64'(out_quotient), 21);
        set_in(1'b0, 0, 0, 1'b1);
        @(negedge clk);
        chk("pp_tail", 64'(out_quotient), 22);
        chk("pp_tail_r", 64'(out_remainder), 3);
        drain();

        // Empty with in_valid and out_ready together
        set_in(1'b1, 30, 4, 1'b1);
        @(negedge clk);
        chk("empty_pp_valid", 64'(out_valid), 1);
        chk("empty_pp_q", 64'(out_quotient), 30);
        chk("empty_pp_count", 64'(count), 1);
        drain();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, W'(40 + i), 0, 1'b0);
            @(negedge clk);
        end
        set_in(1'b0, 0, 0, 1'b0);
        chk("mid_count", 64'(count), 3);
        chk("mid_valid", 64'(out_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 9, 8, 1'b0);
        @(negedge clk);
        set_in(1'b0, 0, 0, 1'b0);
        chk("post_rst_q", 64'(out_quotient), 9);
        chk("post_rst_r", 64'(out_remainder), 8);
        chk("post_rst_count", 64'(count), 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
